// File: rtl/tlb_unit_if.sv
// ---------------------------------------------------------------------------
// tlb_unit_if : CP0 / memory-path bundle for tlb_unit.
//   command side  : cpu_pause_i, tlb_cmd_valid_i, tlb_cmd_i, tlb_busy_o, tlb_done_o
//   CP0 operands  : cp0_entryhi_i, cp0_entrylo0_i, cp0_entrylo1_i,
//                   cp0_index_i, cp0_random_i
//   TLBR / TLBP   : tlb_entry*_o, tlb_entry*_data_valid_o,
//                   tlb_entryhi_match_index_o, tlb_entryhi_hit_o
//   translation   : vaddr_i, vaddr_valid_i, vaddr_write_i, paddr_o,
//                   paddr_valid_o, exception_tlb_*_o, bad_vaddr_o
// Optional feature macro: TLB_FLUSH_EN adds tlb_flush_i.
// master = CP0 / pipeline side, slave = TLB side.
// ---------------------------------------------------------------------------
interface tlb_unit_if;
`ifdef TLB_FLUSH_EN
  logic        tlb_flush_i;
`endif
  logic        cpu_pause_i;
  logic        tlb_cmd_valid_i;
  logic [1:0]  tlb_cmd_i;
  logic        tlb_busy_o;
  logic        tlb_done_o;
  logic [31:0] cp0_entryhi_i;
  logic [31:0] cp0_entrylo0_i;
  logic [31:0] cp0_entrylo1_i;
  logic [31:0] cp0_index_i;
  logic [31:0] cp0_random_i;
  logic [31:0] tlb_entryhi_o;
  logic [31:0] tlb_entrylo0_o;
  logic [31:0] tlb_entrylo1_o;
  logic        tlb_entryhi_data_valid_o;
  logic        tlb_entrylo0_data_valid_o;
  logic        tlb_entrylo1_data_valid_o;
  logic [3:0]  tlb_entryhi_match_index_o;
  logic        tlb_entryhi_hit_o;
  logic [31:0] vaddr_i;
  logic        vaddr_valid_i;
  logic        vaddr_write_i;
  logic [31:0] paddr_o;
  logic        paddr_valid_o;
  logic        exception_tlb_refill_o;
  logic        exception_tlb_invalid_o;
  logic        exception_tlb_mod_o;
  logic        exception_tlb_rw_o;
  logic [31:0] bad_vaddr_o;

  modport master (
`ifdef TLB_FLUSH_EN
    output tlb_flush_i,
`endif
    output cpu_pause_i, tlb_cmd_valid_i, tlb_cmd_i,
    output cp0_entryhi_i, cp0_entrylo0_i, cp0_entrylo1_i, cp0_index_i, cp0_random_i,
    output vaddr_i, vaddr_valid_i, vaddr_write_i,
    input  tlb_busy_o, tlb_done_o,
    input  tlb_entryhi_o, tlb_entrylo0_o, tlb_entrylo1_o,
    input  tlb_entryhi_data_valid_o, tlb_entrylo0_data_valid_o, tlb_entrylo1_data_valid_o,
    input  tlb_entryhi_match_index_o, tlb_entryhi_hit_o,
    input  paddr_o, paddr_valid_o,
    input  exception_tlb_refill_o, exception_tlb_invalid_o, exception_tlb_mod_o,
    input  exception_tlb_rw_o, bad_vaddr_o
  );

  modport slave (
`ifdef TLB_FLUSH_EN
    input  tlb_flush_i,
`endif
    input  cpu_pause_i, tlb_cmd_valid_i, tlb_cmd_i,
    input  cp0_entryhi_i, cp0_entrylo0_i, cp0_entrylo1_i, cp0_index_i, cp0_random_i,
    input  vaddr_i, vaddr_valid_i, vaddr_write_i,
    output tlb_busy_o, tlb_done_o,
    output tlb_entryhi_o, tlb_entrylo0_o, tlb_entrylo1_o,
    output tlb_entryhi_data_valid_o, tlb_entrylo0_data_valid_o, tlb_entrylo1_data_valid_o,
    output tlb_entryhi_match_index_o, tlb_entryhi_hit_o,
    output paddr_o, paddr_valid_o,
    output exception_tlb_refill_o, exception_tlb_invalid_o, exception_tlb_mod_o,
    output exception_tlb_rw_o, bad_vaddr_o
  );
endinterface

// File: rtl/tlb_unit.sv
// ---------------------------------------------------------------------------
// tlb_unit : 16-entry fully associative joint TLB, even/odd 4 KB page pairs.
// Executes TLBR / TLBWI / TLBWR / TLBP for CP0 and translates data-side
// virtual addresses with one cycle of registered latency.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   bus   - tlb_unit_if.slave (command, CP0 operands, read/probe results,
//           translation request and result/exception flags)
// Optional feature macro: TLB_FLUSH_EN (tlb_flush_i clears all V bits).
// ---------------------------------------------------------------------------
module tlb_unit #(
  parameter int unsigned ENTRIES     = 16,
  parameter int unsigned PROBE_START = 0
) (
  input  logic       clk,
  input  logic       reset,
  tlb_unit_if.slave  bus
);

  localparam int unsigned IDX_W   = 4;
  localparam logic [IDX_W-1:0] PTR_FIRST = IDX_W'(PROBE_START);
  localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(ENTRIES - 1);

  localparam logic [1:0] CMD_TLBR  = 2'b00;
  localparam logic [1:0] CMD_TLBWI = 2'b01;
  localparam logic [1:0] CMD_TLBWR = 2'b10;
  localparam logic [1:0] CMD_TLBP  = 2'b11;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } page_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    page_t       p0;
    page_t       p1;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_PROBE} state_t;

  // Entry comparison shared by TLBP and the translation path.
  function automatic logic entry_match(entry_t e, logic [18:0] vpn2, logic [7:0] asid);
    return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
  endfunction

  entry_t tlb_q [ENTRIES];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [18:0]      vpn2_q, vpn2_d;
  logic [7:0]       asid_q, asid_d;
  logic [25:0]      lo0_q, lo0_d;
  logic [25:0]      lo1_q, lo1_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_hi_q, rd_hi_d;
  logic [31:0]      rd_lo0_q, rd_lo0_d;
  logic [31:0]      rd_lo1_q, rd_lo1_d;
  logic [IDX_W-1:0] match_idx_q, match_idx_d;
  logic             hit_q, hit_d;

  logic             arr_we_c;
  logic             flush_c;
  logic             probe_match_c;
  entry_t           wr_entry_c;
  entry_t           rd_entry_c;
  logic             pause_c;

  assign pause_c       = bus.cpu_pause_i;
  assign probe_match_c = entry_match(tlb_q[ptr_q], vpn2_q, asid_q);
  assign rd_entry_c    = tlb_q[idx_q];

  // Entry image built from the captured CP0 operands; G needs both halves global.
  always_comb begin
    wr_entry_c.vpn2 = vpn2_q;
    wr_entry_c.asid = asid_q;
    wr_entry_c.g    = lo0_q[0] & lo1_q[0];
    wr_entry_c.p0   = '{pfn: lo0_q[25:6], c: lo0_q[5:3], d: lo0_q[2], v: lo0_q[1]};
    wr_entry_c.p1   = '{pfn: lo1_q[25:6], c: lo1_q[5:3], d: lo1_q[2], v: lo1_q[1]};
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else if (!pause_c) begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    if (!pause_c) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.tlb_cmd_valid_i) begin
            unique case (bus.tlb_cmd_i)
              CMD_TLBR:  state_d = S_READ;
              CMD_TLBWI: state_d = S_WRITE;
              CMD_TLBWR: state_d = S_WRITE;
              CMD_TLBP:  state_d = S_PROBE;
              default:   state_d = S_IDLE;
            endcase
          end
        end
        S_READ, S_WRITE: state_d = S_IDLE;
        S_PROBE: begin
          if (probe_match_c || (ptr_q == PTR_LAST)) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM output / datapath next values.
  always_comb begin
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    vpn2_d      = vpn2_q;
    asid_d      = asid_q;
    lo0_d       = lo0_q;
    lo1_d       = lo1_q;
    busy_d      = busy_q;
    done_d      = done_q;
    rd_valid_d  = rd_valid_q;
    rd_hi_d     = rd_hi_q;
    rd_lo0_d    = rd_lo0_q;
    rd_lo1_d    = rd_lo1_q;
    match_idx_d = match_idx_q;
    hit_d       = hit_q;
    arr_we_c    = 1'b0;
    flush_c     = 1'b0;
    if (!pause_c) begin
      done_d     = 1'b0;
      rd_valid_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.tlb_cmd_valid_i) begin
            idx_d  = (bus.tlb_cmd_i == CMD_TLBWR) ? bus.cp0_random_i[IDX_W-1:0]
                                                   : bus.cp0_index_i[IDX_W-1:0];
            ptr_d  = PTR_FIRST;
            vpn2_d = bus.cp0_entryhi_i[31:13];
            asid_d = bus.cp0_entryhi_i[7:0];
            lo0_d  = bus.cp0_entrylo0_i[25:0];
            lo1_d  = bus.cp0_entrylo1_i[25:0];
          end
`ifdef TLB_FLUSH_EN
          else if (bus.tlb_flush_i) begin
            flush_c = 1'b1;
            done_d  = 1'b1;
          end
`endif
        end
        S_READ: begin
          rd_hi_d    = {rd_entry_c.vpn2, 5'b0, rd_entry_c.asid};
          rd_lo0_d   = {6'b0, rd_entry_c.p0.pfn, rd_entry_c.p0.c, rd_entry_c.p0.d,
                        rd_entry_c.p0.v, rd_entry_c.g};
          rd_lo1_d   = {6'b0, rd_entry_c.p1.pfn, rd_entry_c.p1.c, rd_entry_c.p1.d,
                        rd_entry_c.p1.v, rd_entry_c.g};
          rd_valid_d = 1'b1;
          done_d     = 1'b1;
        end
        S_WRITE: begin
          arr_we_c = 1'b1;
          done_d   = 1'b1;
        end
        S_PROBE: begin
          if (probe_match_c) begin
            match_idx_d = ptr_q;
            hit_d       = 1'b1;
            done_d      = 1'b1;
          end else if (ptr_q == PTR_LAST) begin
            hit_d  = 1'b0;
            done_d = 1'b1;
          end else begin
            ptr_d = ptr_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
      busy_d = (state_d != S_IDLE);
    end
  end

  // Command datapath and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q       <= '0;
      ptr_q       <= '0;
      vpn2_q      <= '0;
      asid_q      <= '0;
      lo0_q       <= '0;
      lo1_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_hi_q     <= '0;
      rd_lo0_q    <= '0;
      rd_lo1_q    <= '0;
      match_idx_q <= '0;
      hit_q       <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      vpn2_q      <= vpn2_d;
      asid_q      <= asid_d;
      lo0_q       <= lo0_d;
      lo1_q       <= lo1_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      rd_hi_q     <= rd_hi_d;
      rd_lo0_q    <= rd_lo0_d;
      rd_lo1_q    <= rd_lo1_d;
      match_idx_q <= match_idx_d;
      hit_q       <= hit_d;
    end
  end

  // Entry array; write strobes are already gated by pause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tlb_q[i] <= '0;
      end
    end else begin
      if (arr_we_c) begin
        tlb_q[idx_q] <= wr_entry_c;
      end
      if (flush_c) begin
        for (int i = 0; i < int'(ENTRIES); i++) begin
          tlb_q[i].p0.v <= 1'b0;
          tlb_q[i].p1.v <= 1'b0;
        end
      end
    end
  end

  // Translation: parallel match, lowest index wins, live ASID from CP0.
  logic             xl_hit_c;
  logic [IDX_W-1:0] xl_idx_c;
  logic [19:0]      xl_pfn_c;
  logic             xl_v_c;
  logic             xl_d_c;
  logic             xl_unmapped_c;

  always_comb begin
    xl_hit_c = 1'b0;
    xl_idx_c = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (entry_match(tlb_q[i], bus.vaddr_i[31:13], bus.cp0_entryhi_i[7:0])) begin
        xl_hit_c = 1'b1;
        xl_idx_c = IDX_W'(i);
      end
    end
    xl_pfn_c      = bus.vaddr_i[12] ? tlb_q[xl_idx_c].p1.pfn : tlb_q[xl_idx_c].p0.pfn;
    xl_v_c        = bus.vaddr_i[12] ? tlb_q[xl_idx_c].p1.v   : tlb_q[xl_idx_c].p0.v;
    xl_d_c        = bus.vaddr_i[12] ? tlb_q[xl_idx_c].p1.d   : tlb_q[xl_idx_c].p0.d;
    xl_unmapped_c = (bus.vaddr_i[31:30] == 2'b10);
  end

  logic [31:0] paddr_q, paddr_d;
  logic        pvalid_q, pvalid_d;
  logic        refill_q, refill_d;
  logic        inval_q, inval_d;
  logic        mod_q, mod_d;
  logic        rw_q, rw_d;
  logic [31:0] bad_q, bad_d;

  // Translation result next values; refill > invalid > mod.
  always_comb begin
    paddr_d  = paddr_q;
    bad_d    = bad_q;
    rw_d     = rw_q;
    pvalid_d = 1'b0;
    refill_d = 1'b0;
    inval_d  = 1'b0;
    mod_d    = 1'b0;
    if (bus.vaddr_valid_i) begin
      bad_d = bus.vaddr_i;
      rw_d  = bus.vaddr_write_i;
      if (xl_unmapped_c) begin
        paddr_d  = {3'b0, bus.vaddr_i[28:0]};
        pvalid_d = 1'b1;
      end else begin
        paddr_d = {xl_pfn_c, bus.vaddr_i[11:0]};
        if (!xl_hit_c) begin
          refill_d = 1'b1;
        end else if (!xl_v_c) begin
          inval_d = 1'b1;
        end else if (bus.vaddr_write_i && !xl_d_c) begin
          mod_d = 1'b1;
        end else begin
          pvalid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      paddr_q  <= '0;
      pvalid_q <= 1'b0;
      refill_q <= 1'b0;
      inval_q  <= 1'b0;
      mod_q    <= 1'b0;
      rw_q     <= 1'b0;
      bad_q    <= '0;
    end else if (!pause_c) begin
      paddr_q  <= paddr_d;
      pvalid_q <= pvalid_d;
      refill_q <= refill_d;
      inval_q  <= inval_d;
      mod_q    <= mod_d;
      rw_q     <= rw_d;
      bad_q    <= bad_d;
    end
  end

  // Operand bits outside the architected fields are ignored.
  logic unused_bits_c;
  assign unused_bits_c = ^{bus.cp0_index_i[31:IDX_W], bus.cp0_random_i[31:IDX_W],
                           bus.cp0_entryhi_i[12:8], bus.cp0_entrylo0_i[31:26],
                           bus.cp0_entrylo1_i[31:26]};

  assign bus.tlb_busy_o                = busy_q;
  assign bus.tlb_done_o                = done_q;
  assign bus.tlb_entryhi_o             = rd_hi_q;
  assign bus.tlb_entrylo0_o            = rd_lo0_q;
  assign bus.tlb_entrylo1_o            = rd_lo1_q;
  assign bus.tlb_entryhi_data_valid_o  = rd_valid_q;
  assign bus.tlb_entrylo0_data_valid_o = rd_valid_q;
  assign bus.tlb_entrylo1_data_valid_o = rd_valid_q;
  assign bus.tlb_entryhi_match_index_o = match_idx_q;
  assign bus.tlb_entryhi_hit_o         = hit_q;
  assign bus.paddr_o                   = paddr_q;
  assign bus.paddr_valid_o             = pvalid_q;
  assign bus.exception_tlb_refill_o    = refill_q;
  assign bus.exception_tlb_invalid_o   = inval_q;
  assign bus.exception_tlb_mod_o       = mod_q;
  assign bus.exception_tlb_rw_o        = rw_q;
  assign bus.bad_vaddr_o               = bad_q;

endmodule

// File: tb/tb_tlb_unit.sv
// ---------------------------------------------------------------------------
// tb_tlb_unit : directed self-checking bench for tlb_unit.
// Expected translation and TLBR results are queued when stimulus is driven
// and popped when the DUT presents its registered result.
// ---------------------------------------------------------------------------
module tb_tlb_unit;

  localparam logic [1:0] C_TLBR  = 2'b00;
  localparam logic [1:0] C_TLBWI = 2'b01;
  localparam logic [1:0] C_TLBWR = 2'b10;
  localparam logic [1:0] C_TLBP  = 2'b11;

  localparam logic [2:0] X_NONE   = 3'b000;
  localparam logic [2:0] X_REFILL = 3'b100;
  localparam logic [2:0] X_INVAL  = 3'b010;
  localparam logic [2:0] X_MOD    = 3'b001;

  logic clk = 1'b0;
  logic reset;

  tlb_unit_if bus ();

  tlb_unit #(.ENTRIES(16), .PROBE_START(0)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] va;
    logic        wr;
    logic [31:0] pa;
    logic        valid;
    logic [2:0]  exc;
  } xl_exp_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo0;
    logic [31:0] lo1;
  } rd_exp_t;

  xl_exp_t xl_q[$];
  rd_exp_t rd_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One translation request; result compared one cycle later.
  task automatic xlate(input string tag, input logic [31:0] va, input logic wr,
                       input logic [31:0] pa, input logic valid, input logic [2:0] exc);
    xl_exp_t e;
    xl_exp_t got;
    e.va = va; e.wr = wr; e.pa = pa; e.valid = valid; e.exc = exc;
    xl_q.push_back(e);
    bus.vaddr_i       = va;
    bus.vaddr_write_i = wr;
    bus.vaddr_valid_i = 1'b1;
    @(negedge clk);
    bus.vaddr_valid_i = 1'b0;
    bus.vaddr_write_i = 1'b0;
    got = xl_q.pop_front();
    check({tag, "/valid"},  32'(bus.paddr_valid_o),           32'(got.valid));
    check({tag, "/refill"}, 32'(bus.exception_tlb_refill_o),  32'(got.exc[2]));
    check({tag, "/inval"},  32'(bus.exception_tlb_invalid_o), 32'(got.exc[1]));
    check({tag, "/mod"},    32'(bus.exception_tlb_mod_o),     32'(got.exc[0]));
    check({tag, "/rw"},     32'(bus.exception_tlb_rw_o),      32'(got.wr));
    check({tag, "/bad"},    bus.bad_vaddr_o,                  got.va);
    if (got.valid) check({tag, "/paddr"}, bus.paddr_o, got.pa);
  endtask

  // Issue one command, optionally pause after accept, and time completion.
  task automatic run_cmd(input string tag, input logic [1:0] c, input logic [31:0] hi,
                         input logic [31:0] lo0, input logic [31:0] lo1,
                         input logic [3:0] idx, input logic [3:0] rnd,
                         input int pause_cyc, input int exp_lat);
    int lat;
    logic seen;
    rd_exp_t r;
    bus.tlb_cmd_i       = c;
    bus.cp0_entryhi_i   = hi;
    bus.cp0_entrylo0_i  = lo0;
    bus.cp0_entrylo1_i  = lo1;
    bus.cp0_index_i     = {28'h0, idx};
    bus.cp0_random_i    = {28'h0, rnd};
    bus.tlb_cmd_valid_i = 1'b1;
    @(negedge clk);
    bus.tlb_cmd_valid_i = 1'b0;
    check({tag, "/busy_rise"}, 32'(bus.tlb_busy_o), 32'd1);
    lat = 0;
    if (pause_cyc > 0) begin
      bus.cpu_pause_i = 1'b1;
      repeat (pause_cyc) @(negedge clk);
      bus.cpu_pause_i = 1'b0;
      lat = pause_cyc;
    end
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      seen = bus.tlb_done_o;
    end
    check({tag, "/done_seen"}, 32'(seen), 32'd1);
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/busy_fall"}, 32'(bus.tlb_busy_o), 32'd0);
    if (c == C_TLBR) begin
      r = rd_q.pop_front();
      check({tag, "/hi_dv"},  32'(bus.tlb_entryhi_data_valid_o),  32'd1);
      check({tag, "/lo0_dv"}, 32'(bus.tlb_entrylo0_data_valid_o), 32'd1);
      check({tag, "/lo1_dv"}, 32'(bus.tlb_entrylo1_data_valid_o), 32'd1);
      check({tag, "/hi"},  bus.tlb_entryhi_o,  r.hi);
      check({tag, "/lo0"}, bus.tlb_entrylo0_o, r.lo0);
      check({tag, "/lo1"}, bus.tlb_entrylo1_o, r.lo1);
    end
    @(negedge clk);
    check({tag, "/done_pulse"}, 32'(bus.tlb_done_o), 32'd0);
    check({tag, "/dv_pulse"}, 32'(bus.tlb_entryhi_data_valid_o), 32'd0);
  endtask

  function automatic rd_exp_t mk_rd(input logic [31:0] hi, input logic [31:0] lo0,
                                    input logic [31:0] lo1);
    rd_exp_t r;
    r.hi = hi; r.lo0 = lo0; r.lo1 = lo1;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
`ifdef TLB_FLUSH_EN
    bus.tlb_flush_i = 1'b0;
`endif
    bus.cpu_pause_i     = 1'b0;
    bus.tlb_cmd_valid_i = 1'b0;
    bus.tlb_cmd_i       = 2'b00;
    bus.cp0_entryhi_i   = '0;
    bus.cp0_entrylo0_i  = '0;
    bus.cp0_entrylo1_i  = '0;
    bus.cp0_index_i     = '0;
    bus.cp0_random_i    = '0;
    bus.vaddr_i         = '0;
    bus.vaddr_valid_i   = 1'b0;
    bus.vaddr_write_i   = 1'b0;
    repeat (2) @(negedge clk);

    check("rst/busy",   32'(bus.tlb_busy_o), 32'd0);
    check("rst/done",   32'(bus.tlb_done_o), 32'd0);
    check("rst/hit",    32'(bus.tlb_entryhi_hit_o), 32'd0);
    check("rst/pvalid", 32'(bus.paddr_valid_o), 32'd0);
    check("rst/hi",     bus.tlb_entryhi_o, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Empty TLB: mapped address misses.
    xlate("miss0", 32'h0040_1000, 1'b0, 32'h0, 1'b0, X_REFILL);

    // Entry 3: VPN2 0x200, ASID 5, even page PFN 0x41 D=1 V=1, odd page invalid.
    run_cmd("wi3", C_TLBWI, 32'h0040_0005, 32'h0000_1046, 32'h0, 4'd3, 4'd9, 0, 1);
    bus.cp0_entryhi_i = 32'h0000_0005;
    xlate("even_ld", 32'h0040_0ABC, 1'b0, 32'h0004_1ABC, 1'b1, X_NONE);
    xlate("odd_inv", 32'h0040_1ABC, 1'b0, 32'h0, 1'b0, X_INVAL);
    xlate("even_st", 32'h0040_0ABC, 1'b1, 32'h0004_1ABC, 1'b1, X_NONE);
    @(negedge clk);
    check("idle/pvalid", 32'(bus.paddr_valid_o), 32'd0);
    check("idle/inval",  32'(bus.exception_tlb_invalid_o), 32'd0);
    check("idle/bad",    bus.bad_vaddr_o, 32'h0040_0ABC);
    bus.cp0_entryhi_i = 32'h0000_0006;
    xlate("asid_miss", 32'h0040_0ABC, 1'b0, 32'h0, 1'b0, X_REFILL);

    // Same entry with D=0: store raises mod.
    run_cmd("wi3_d0", C_TLBWI, 32'h0040_0005, 32'h0000_1042, 32'h0, 4'd3, 4'd0, 0, 1);
    bus.cp0_entryhi_i = 32'h0000_0005;
    xlate("mod_st", 32'h0040_0000, 1'b1, 32'h0, 1'b0, X_MOD);
    xlate("d0_ld",  32'h0040_0010, 1'b0, 32'h0004_1010, 1'b1, X_NONE);

    // TLBR with a 3-cycle pause, then without.
    rd_q.push_back(mk_rd(32'h0040_0005, 32'h0000_1042, 32'h0));
    run_cmd("tlbr3_pause", C_TLBR, 32'h0, 32'h0, 32'h0, 4'd3, 4'd0, 3, 4);
    rd_q.push_back(mk_rd(32'h0040_0005, 32'h0000_1042, 32'h0));
    run_cmd("tlbr3", C_TLBR, 32'h0, 32'h0, 32'h0, 4'd3, 4'd7, 0, 1);

    // Entry 12 via random: global, VPN2 0x400, PFN 0x123 / 0x124 (odd D=0).
    run_cmd("wr12", C_TLBWR, 32'h0080_0007, 32'h0000_48C7, 32'h0000_4903, 4'd0, 4'd12, 0, 1);
    run_cmd("probe12", C_TLBP, 32'h0080_0099, 32'h0, 32'h0, 4'd0, 4'd0, 0, 13);
    check("probe12/hit", 32'(bus.tlb_entryhi_hit_o), 32'd1);
    check("probe12/idx", 32'(bus.tlb_entryhi_match_index_o), 32'd12);
    run_cmd("probe_miss", C_TLBP, 32'h1234_0005, 32'h0, 32'h0, 4'd0, 4'd0, 0, 16);
    check("probe_miss/hit", 32'(bus.tlb_entryhi_hit_o), 32'd0);
    check("probe_miss/idx", 32'(bus.tlb_entryhi_match_index_o), 32'd12);

    // Read-back returns G in both lo words.
    rd_q.push_back(mk_rd(32'h0080_0007, 32'h0000_48C7, 32'h0000_4903));
    run_cmd("tlbr12", C_TLBR, 32'h0, 32'h0, 32'h0, 4'd12, 4'd0, 0, 1);

    // Global entry hits under a foreign ASID; unmapped window bypasses the TLB.
    bus.cp0_entryhi_i = 32'h0000_0033;
    xlate("g_odd",  32'h0080_1234, 1'b0, 32'h0012_4234, 1'b1, X_NONE);
    xlate("g_even", 32'h0080_0234, 1'b1, 32'h0012_3234, 1'b1, X_NONE);
    xlate("g_mod",  32'h0080_1000, 1'b1, 32'h0, 1'b0, X_MOD);
    xlate("unmap",  32'hA000_1234, 1'b0, 32'h0000_1234, 1'b1, X_NONE);

    // Entry 5 duplicates VPN2 0x400: lowest index must win everywhere.
    run_cmd("wi5", C_TLBWI, 32'h0080_0001, 32'h0001_5547, 32'h0001_5583, 4'd5, 4'd0, 0, 1);
    bus.cp0_entryhi_i = 32'h0000_0033;
    xlate("prio", 32'h0080_0234, 1'b0, 32'h0055_5234, 1'b1, X_NONE);
    run_cmd("probe5", C_TLBP, 32'h0080_0099, 32'h0, 32'h0, 4'd0, 4'd0, 0, 6);
    check("probe5/hit", 32'(bus.tlb_entryhi_hit_o), 32'd1);
    check("probe5/idx", 32'(bus.tlb_entryhi_match_index_o), 32'd5);

    // Reset in the middle of a probe.
    bus.tlb_cmd_i       = C_TLBP;
    bus.cp0_entryhi_i   = 32'h1234_0005;
    bus.tlb_cmd_valid_i = 1'b1;
    @(negedge clk);
    bus.tlb_cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rstp/busy_before", 32'(bus.tlb_busy_o), 32'd1);
    reset = 1'b1;
    #1;
    check("rstp/hit",  32'(bus.tlb_entryhi_hit_o), 32'd0);
    check("rstp/busy", 32'(bus.tlb_busy_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rstp/idle", 32'(bus.tlb_busy_o), 32'd0);
    bus.cp0_entryhi_i = 32'h0000_0033;
    xlate("rstp_cleared", 32'h0080_0234, 1'b0, 32'h0, 1'b0, X_REFILL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
